// File: rtl/lcd_spi_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_spi_arb_pkg
// Description : Shared state encoding and default timing constants for the
//               LCD SPI burst arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_spi_arb_pkg;

  localparam int CS_SETUP_DEF = 2;
  localparam int CS_HOLD_DEF  = 2;
  localparam int TIMEOUT_DEF  = 255;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETUP     = 3'd1,
    ST_WAIT_BYTE = 3'd2,
    ST_SHIFT     = 3'd3,
    ST_HOLD      = 3'd4
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/lcd_spi_arb_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way combinational round-robin decision. A single request
//               always wins; on contention the requester that was not
//               granted last wins.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_gnt,   // index of the requester granted last
  output logic [1:0] gnt
);

  // One-hot pick with fairness only mattering when both request
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lcd_spi_arb.sv
`default_nettype none
// ============================================================================
// Module      : lcd_spi_arb
// Description : Arbitrates two byte-stream requesters (CPU, LCD refresh)
//               onto one shared SPI byte engine, framing each burst with
//               lcd_cs_n setup/hold and driving lcd_dc per byte.
//               Optional feature macro: LCD_ARB_TIMEOUT_EN enables the
//               WAIT_BYTE stall timeout; without it the timeout port is 0.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_spi_arb
  import lcd_spi_arb_pkg::*;
#(
  parameter int CS_SETUP = CS_SETUP_DEF,
  parameter int CS_HOLD  = CS_HOLD_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic        clk24,
  input  logic        reset,
  input  logic [1:0]  req,
  output logic [1:0]  gnt,
  input  logic [1:0]  wvalid,
  output logic [1:0]  wready,
  input  logic [15:0] wdata,
  input  logic [1:0]  wdc,
  input  logic [1:0]  wlast,
  output logic [7:0]  rdata,
  output logic [1:0]  rvalid,
  output logic        timeout,
  output logic        spi_start,
  output logic [7:0]  spi_tx,
  input  logic        spi_done,
  input  logic [7:0]  spi_rx,
  output logic        lcd_cs_n,
  output logic        lcd_dc
);

  localparam logic [7:0] C_SETUP_LAST = 8'(CS_SETUP - 1);
  localparam logic [7:0] C_HOLD_LAST  = 8'(CS_HOLD - 1);
  localparam logic [7:0] C_TO_LAST    = 8'(TIMEOUT - 1);
`ifdef LCD_ARB_TIMEOUT_EN
  localparam logic C_TO_EN = 1'b1;
`else
  localparam logic C_TO_EN = 1'b0;
`endif

  arb_state_e state_q, state_d;
  logic [1:0] gnt_q, gnt_d;
  logic [1:0] wready_q, wready_d;
  logic [1:0] rvalid_q, rvalid_d;
  logic [7:0] rdata_q, rdata_d;
  logic [7:0] spi_tx_q, spi_tx_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] to_cnt_q, to_cnt_d;
  logic       spi_start_q, spi_start_d;
  logic       cs_n_q, cs_n_d;
  logic       dc_q, dc_d;
  logic       last_q, last_d;
  logic       timeout_q, timeout_d;
  logic       rr_last_q, rr_last_d;

  logic [1:0] w_rr_gnt;
  logic       w_sel;
  logic [7:0] w_byte;
  logic       w_hs;

  rr_arb2 u_rr_arb2 (
    .req      (req),
    .last_gnt (rr_last_q),
    .gnt      (w_rr_gnt)
  );

  // Only the granted lane can handshake because wready_q carries only its bit
  assign w_sel  = gnt_q[1];
  assign w_byte = w_sel ? wdata[15:8] : wdata[7:0];
  assign w_hs   = |(wvalid & wready_q);

  // Next-state and registered-output computation for the burst FSM
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    wready_d    = wready_q;
    rvalid_d    = 2'b00;
    rdata_d     = rdata_q;
    spi_tx_d    = spi_tx_q;
    cnt_d       = cnt_q;
    to_cnt_d    = 8'd0;
    spi_start_d = 1'b0;
    cs_n_d      = cs_n_q;
    dc_d        = dc_q;
    last_d      = last_q;
    timeout_d   = 1'b0;
    rr_last_d   = rr_last_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          gnt_d   = w_rr_gnt;
          cs_n_d  = 1'b0;
          cnt_d   = 8'd0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == C_SETUP_LAST) begin
          cnt_d    = 8'd0;
          wready_d = gnt_q;
          state_d  = ST_WAIT_BYTE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_WAIT_BYTE: begin
        if (w_hs) begin
          spi_tx_d    = w_byte;
          dc_d        = wdc[w_sel];
          last_d      = wlast[w_sel];
          wready_d    = 2'b00;
          spi_start_d = 1'b1;
          state_d     = ST_SHIFT;
        end else if (C_TO_EN) begin
          if (to_cnt_q == C_TO_LAST) begin
            timeout_d = 1'b1;
            wready_d  = 2'b00;
            cnt_d     = 8'd0;
            state_d   = ST_HOLD;
          end else begin
            to_cnt_d = to_cnt_q + 8'd1;
          end
        end
      end
      ST_SHIFT: begin
        // spi_tx_q is left untouched so it stays stable until spi_done
        if (spi_done) begin
          rdata_d  = spi_rx;
          rvalid_d = gnt_q;
          if (last_q) begin
            cnt_d   = 8'd0;
            state_d = ST_HOLD;
          end else begin
            wready_d = gnt_q;
            state_d  = ST_WAIT_BYTE;
          end
        end
      end
      ST_HOLD: begin
        if (cnt_q == C_HOLD_LAST) begin
          cs_n_d    = 1'b1;
          gnt_d     = 2'b00;
          rr_last_d = gnt_q[1];
          cnt_d     = 8'd0;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; pointer resets so requester 0 wins first
  always_ff @(posedge clk24) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      gnt_q       <= 2'b00;
      wready_q    <= 2'b00;
      rvalid_q    <= 2'b00;
      rdata_q     <= 8'd0;
      spi_tx_q    <= 8'd0;
      cnt_q       <= 8'd0;
      to_cnt_q    <= 8'd0;
      spi_start_q <= 1'b0;
      cs_n_q      <= 1'b1;
      dc_q        <= 1'b0;
      last_q      <= 1'b0;
      timeout_q   <= 1'b0;
      rr_last_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      wready_q    <= wready_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      spi_tx_q    <= spi_tx_d;
      cnt_q       <= cnt_d;
      to_cnt_q    <= to_cnt_d;
      spi_start_q <= spi_start_d;
      cs_n_q      <= cs_n_d;
      dc_q        <= dc_d;
      last_q      <= last_d;
      timeout_q   <= timeout_d;
      rr_last_q   <= rr_last_d;
    end
  end

  assign gnt       = gnt_q;
  assign wready    = wready_q;
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign timeout   = timeout_q;
  assign spi_start = spi_start_q;
  assign spi_tx    = spi_tx_q;
  assign lcd_cs_n  = cs_n_q;
  assign lcd_dc    = dc_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_spi_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_spi_arb
// Description : Randomized self-checking bench for lcd_spi_arb with a
//               transaction-level model (round-robin owner, byte/dc order,
//               returned SPI bytes, setup/hold lengths) and an SPI engine
//               model with random latency. Honours LCD_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_spi_arb;

  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int TIMEOUT  = 16;

  logic        clk24 = 1'b0;
  logic        reset;
  logic [1:0]  req, gnt, wvalid, wready, wdc, wlast, rvalid;
  logic [15:0] wdata;
  logic [7:0]  rdata, spi_tx, spi_rx;
  logic        timeout, spi_start, spi_done, lcd_cs_n, lcd_dc;

  lcd_spi_arb #(.CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .TIMEOUT(TIMEOUT)) dut (
    .clk24(clk24), .reset(reset), .req(req), .gnt(gnt),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wdc(wdc), .wlast(wlast),
    .rdata(rdata), .rvalid(rvalid), .timeout(timeout),
    .spi_start(spi_start), .spi_tx(spi_tx), .spi_done(spi_done), .spi_rx(spi_rx),
    .lcd_cs_n(lcd_cs_n), .lcd_dc(lcd_dc)
  );

  initial forever #21 clk24 = ~clk24;

  int         n_chk = 0;
  int         n_pass = 0;
  int         n_start = 0;
  int         n_rv = 0;
  logic       rr_last = 1'b1;   // model: index of requester granted last
  logic [7:0] rx_q[$];          // bytes the SPI engine model has returned
  logic [7:0] bq[$];            // bytes of the next burst
  logic       dq[$];            // dc of the next burst
  bit         rogue = 1'b0;
  bit         force_rx = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One clock step, sampled on the falling edge
  task automatic tick();
    @(negedge clk24);
    if (spi_start === 1'b1) n_start++;
    if (rvalid !== 2'b00) n_rv++;
    check("wready_only_granted", 32'(wready & ~gnt), 32'd0);
  endtask

  task automatic add(input logic [7:0] b, input logic dc);
    bq.push_back(b);
    dq.push_back(dc);
  endtask

  task automatic do_reset();
    reset = 1'b1; req = 2'b00; wvalid = 2'b00; wdata = 16'd0; wdc = 2'b00; wlast = 2'b00;
    tick(); tick();
    reset = 1'b0;
    rr_last = 1'b1;
    rx_q.delete();
  endtask

  // SPI byte engine: answers each spi_start after 1..4 cycles
  initial begin : spi_engine
    int         d;
    logic [7:0] rx;
    spi_done = 1'b0;
    spi_rx = 8'd0;
    forever begin
      @(negedge clk24);
      if (spi_start === 1'b1) begin
        d = $urandom_range(1, 4);
        repeat (d) @(negedge clk24);
        rx = force_rx ? 8'h5A : 8'($urandom);
        spi_done = 1'b1;
        spi_rx = rx;
        rx_q.push_back(rx);
        @(negedge clk24);
        spi_done = 1'b0;
      end
    end
  end

  task automatic send_byte(input int own, input logic [7:0] b, input logic dc, input logic last);
    logic [1:0] oh;
    logic [7:0] rx;
    int         n;
    oh = 2'(1 << own);
    wdata = 16'($urandom);
    wdata[own*8 +: 8] = b;
    wdc[own] = dc;
    wlast[own] = last;
    wvalid[own] = 1'b1;
    n = 0;
    while (wready[own] !== 1'b1 && n < 50) begin tick(); n++; end
    check("wready_seen", 32'(wready[own]), 32'd1);
    tick();
    wvalid[own] = 1'b0;
    wlast[own] = 1'b0;
    check("spi_start", 32'(spi_start), 32'd1);
    check("spi_tx", 32'(spi_tx), 32'(b));
    check("lcd_dc", 32'(lcd_dc), 32'(dc));
    check("wready_drop", 32'(wready), 32'd0);
    n = 0;
    do begin
      tick();
      n++;
      if (rvalid === 2'b00) begin
        check("start_one_cycle", 32'(spi_start), 32'd0);
        check("tx_stable", 32'(spi_tx), 32'(b));
      end
    end while (rvalid === 2'b00 && n < 50);
    check("rvalid", 32'(rvalid), 32'(oh));
    rx = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
    check("rdata", 32'(rdata), 32'(rx));
    check("wready_after", 32'(wready), last ? 32'd0 : 32'(oh));
  endtask

  // One full burst from the bytes in bq/dq; owner predicted by round-robin
  task automatic do_burst(input logic [1:0] rq, input bit drop_early);
    int         own, n, s0, nb;
    logic [1:0] oh;
    nb = bq.size();
    own = (rq == 2'b11) ? (rr_last ? 0 : 1) : (rq[1] ? 1 : 0);
    oh = 2'(1 << own);
    req = rq;
    wvalid = rogue ? ~oh : 2'b00;
    wlast = rogue ? ~oh : 2'b00;
    if (rogue) wdata[(1-own)*8 +: 8] = 8'hC3;
    s0 = n_start;
    tick();
    check("gnt", 32'(gnt), 32'(oh));
    check("cs_n_fall", 32'(lcd_cs_n), 32'd0);
    if (drop_early) req[own] = 1'b0;
    n = 0;
    while (wready === 2'b00 && n < 50) begin tick(); n++; end
    check("setup_len", 32'(n), 32'(CS_SETUP));
    for (int k = 0; k < nb; k++) begin
      repeat ($urandom_range(0, 2)) tick();
      if (k == nb - 1) req[own] = 1'b0;
      send_byte(own, bq[k], dq[k], k == nb - 1);
    end
    n = 0;
    while (lcd_cs_n !== 1'b1 && n < 50) begin
      tick();
      n++;
      if (n == 1) check("rvalid_one_cycle", 32'(rvalid), 32'd0);
    end
    check("hold_len", 32'(n), 32'(CS_HOLD));
    check("gnt_release", 32'(gnt), 32'd0);
    check("n_spi_start", 32'(n_start - s0), 32'(nb));
    check("dc_held", 32'(lcd_dc), 32'(dq[nb-1]));
    rr_last = own[0];
    wvalid = 2'b00;
    wlast = 2'b00;
    bq.delete();
    dq.delete();
  endtask

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n, s;
    logic [1:0] rq;
    do_reset();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_spi_start", 32'(spi_start), 32'd0);
    check("rst_spi_tx", 32'(spi_tx), 32'd0);
    check("rst_cs_n", 32'(lcd_cs_n), 32'd1);
    check("rst_dc", 32'(lcd_dc), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);

    // 3-byte command/data burst from the CPU
    add(8'h2A, 1'b0); add(8'h00, 1'b1); add(8'hEF, 1'b1);
    do_burst(2'b01, 1'b0);

    // contention after reset: 0 first, then 1
    do_reset();
    add(8'h11, 1'b0); do_burst(2'b11, 1'b0);
    add(8'h22, 1'b1); do_burst(2'b11, 1'b0);
    add(8'h33, 1'b0); do_burst(2'b01, 1'b0);

    // requester 1 pushes bytes while 0 owns the bus
    do_reset();
    rogue = 1'b1;
    add(8'h44, 1'b1); add(8'h55, 1'b0);
    do_burst(2'b11, 1'b0);
    rogue = 1'b0;
    add(8'h66, 1'b1);
    do_burst(2'b10, 1'b0);

    // single-byte burst with a known returned byte
    force_rx = 1'b1;
    add(8'h96, 1'b1);
    do_burst(2'b01, 1'b0);
    force_rx = 1'b0;
    check("rdata_5a", 32'(rdata), 32'h5A);

    // randomized bursts with contention and early req drop
    for (int it = 0; it < 10; it++) begin
      rq = 2'($urandom_range(1, 3));
      for (int k = 0; k < int'($urandom_range(1, 4)); k++) add(8'($urandom), 1'($urandom));
      do_burst(rq, 1'($urandom));
      while (req != 2'b00) begin
        for (int k = 0; k < int'($urandom_range(1, 4)); k++) add(8'($urandom), 1'($urandom));
        do_burst(req, 1'($urandom));
      end
    end

    // reset during SHIFT, late spi_done must be ignored
    do_reset();
    req = 2'b01; wdata = 16'h00A5; wdc = 2'b01; wlast = 2'b01;
    n = 0;
    while (wready[0] !== 1'b1 && n < 50) begin tick(); n++; end
    wvalid[0] = 1'b1;
    tick();
    wvalid = 2'b00; req = 2'b00;
    check("rs_in_shift", 32'(spi_start), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rs_cs_n", 32'(lcd_cs_n), 32'd1);
    check("rs_gnt", 32'(gnt), 32'd0);
    check("rs_spi_start", 32'(spi_start), 32'd0);
    check("rs_spi_tx", 32'(spi_tx), 32'd0);
    check("rs_dc", 32'(lcd_dc), 32'd0);
    s = n_rv;
    repeat (8) tick();
    check("rs_no_rvalid", 32'(n_rv - s), 32'd0);
    rx_q.delete();
    rr_last = 1'b1;

    // stalled requester
    do_reset();
    req = 2'b01;
    n = 0;
    while (wready[0] !== 1'b1 && n < 50) begin tick(); n++; end
    req = 2'b00;
`ifdef LCD_ARB_TIMEOUT_EN
    n = 0;
    while (timeout !== 1'b1 && n < 100) begin tick(); n++; end
    check("to_delay", 32'(n), 32'(TIMEOUT));
    check("to_wready", 32'(wready), 32'd0);
    tick();
    check("to_one_cycle", 32'(timeout), 32'd0);
    n = 1;
    while (lcd_cs_n !== 1'b1 && n < 50) begin tick(); n++; end
    check("to_hold", 32'(n), 32'(CS_HOLD));
    check("to_gnt", 32'(gnt), 32'd0);
`else
    repeat (3 * TIMEOUT) begin
      tick();
      check("stall_no_timeout", 32'(timeout), 32'd0);
    end
    check("stall_gnt", 32'(gnt), 32'd1);
    check("stall_cs_n", 32'(lcd_cs_n), 32'd0);
    send_byte(0, 8'h3C, 1'b0, 1'b1);
    n = 0;
    while (lcd_cs_n !== 1'b1 && n < 50) begin tick(); n++; end
    check("stall_hold", 32'(n), 32'(CS_HOLD));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
